riscv_lsu: RTL
==============

// Module: riscv_lsu
// PURPOSE
//  Load/store unit between the RV32I core datapath and the single-port data RAM.
//  - Turns core load/store requests (funct3 size code) into RAM requests: byte-enable map, replicated write data, masked address.
//  - RAM read data is registered with 1-cycle latency. The LSU stalls the core for one cycle, then returns the selected byte/half/word, sign- or zero-extended.
// PARAMETERS
//  MEM_SIZE        256  data RAM size in bytes, power of 2; address wraps modulo MEM_SIZE
//  STALL_ON_STORE  1    1: stores take the same 2-cycle sequence as loads; 0: stores complete in 1 cycle, no stall
// PORTS
//  clk                     in   1   clock, rising edge
//  reset                   in   1   synchronous, active-low
//  lsu_req_i               in   1   core requests a memory access this cycle
//  lsu_we_i                in   1   1 = store, 0 = load
//  lsu_size_i              in   3   funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
//  lsu_addr_i              in   32  byte address
//  lsu_data_i              in   32  store data (rs2)
//  lsu_data_o              out  32  extended load result
//  lsu_stall_req_o         out  1   1 = core must hold PC and pipeline
//  data_require_o          out  1   RAM request
//  data_write_enable_o     out  1   RAM write enable
//  data_byte_enable_map_o  out  4   RAM byte lanes
//  data_address_o          out  32  lsu_addr_i & (MEM_SIZE-1)
//  data_write_o            out  32  lane-replicated store data
//  data_read_i             in   32  RAM registered read word
// BEHAVIOUR
//  FSM states
//  - IDLE -> DONE: in IDLE with lsu_req_i=1 and a valid size. Exception: stores with STALL_ON_STORE=0 stay in IDLE.
//  - DONE -> IDLE: unconditional.
//  Cycle rules
//  - IDLE with a valid request: data_require_o=1 (combinational), lsu_stall_req_o=1. addr[1:0] and lsu_size_i are latched at the clock edge.
//  - DONE: data_require_o=0, lsu_stall_req_o=0. lsu_data_o is extracted from data_read_i using the latched offset and size. The core advances at the end of DONE.
//  - lsu_req_i still high in DONE (same instruction) must not re-issue the access.
//  - Load-to-data latency: 1 cycle (result valid in the DONE cycle).
//  - Store with STALL_ON_STORE=0: data_require_o=1 in IDLE, stall=0, no state change.
//  Lane rules (off = addr[1:0])
//  - SB: BE = 4'b0001<<off; data_write_o = {4{d[7:0]}}
//  - SH: BE = 4'b0011<<(off[1]*2); data_write_o = {2{d[15:0]}}
//  - SW: BE = 4'b1111; data_write_o = d
//  - Loads drive BE = 4'b1111 and data_write_enable_o=0.
//  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
//  Invalid size (3,6,7): no RAM request, no stall, lsu_data_o=0.
//  Output defaults
//  - lsu_data_o=0 whenever state!=DONE.
//  - All RAM outputs are 0 whenever data_require_o=0.
//  Address wrap: MEM_SIZE-1 masking. Example: MEM_SIZE=256, addr 0x104 -> data_address_o=0x04.
//  Reset (reset=0 at an edge), including mid-operation
//  - state -> IDLE; latched offset/size -> 0.
//  - While reset is low: data_require_o=0, lsu_stall_req_o=0, lsu_data_o=0.
//  - An access in flight is abandoned and not retried.
// CONFIGURATION
//  LSU_MISALIGN_EXC_EN
//  - Defined:
//    - A halfword with off[0]=1, or a word with off!=0, issues no RAM request and no stall.
//    - New output lsu_misaligned_o (1 bit) pulses high for that cycle; it is 0 during reset.
//  - Not defined:
//    - No lsu_misaligned_o port.
//    - Misaligned addresses are aligned down: halfword uses off[1] only, word ignores off.
//    - The access proceeds normally.
// TESTING
//  1. SW addr 0x08 d=0xDEADBEEF
//     -> req=1 we=1 BE=1111 addr=0x08 wr=0xDEADBEEF, stall 1 cycle.
//  2. LB addr 0x0B, RAM word 0x80FF1234
//     -> stall 1 cycle, then lsu_data_o=0xFFFFFF80.
//     LBU at the same address -> 0x00000080.
//  3. SH addr 0x06 d=0x0000ABCD -> BE=1100 wr=0xABCDABCD.
//     Then LHU addr 0x06 -> 0x0000ABCD.
//  4. Back-to-back LW 0x00 then LW 0x04, lsu_req_i held high
//     -> exactly 2 RAM requests, 4 cycles total, no duplicate request in DONE.
//  5. reset=0 asserted during DONE of a load
//     -> next cycle stall=0, lsu_data_o=0, data_require_o=0, state IDLE.
//  6. LW addr 0x102 (MEM_SIZE=256)
//     - Macro undefined -> data_address_o=0x02, result is the word at 0x00.
//     - Macro defined -> lsu_misaligned_o=1, data_require_o=0, stall=0.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit between the RV32I core and a single-port data RAM with registered read data.
// Optional macro LSU_MISALIGN_EXC_EN: misaligned half/word accesses are refused and flagged on lsu_misaligned_o.
module riscv_lsu #(
  parameter int MEM_SIZE       = 256,
  parameter bit STALL_ON_STORE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        data_require_o,
  output logic        data_write_enable_o,
  output logic [3:0]  data_byte_enable_map_o,
  output logic [31:0] data_address_o,
  output logic [31:0] data_write_o,
  input  logic [31:0] data_read_i
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic        lsu_misaligned_o
`endif
);

  typedef enum logic {IDLE, DONE} state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_SIZE - 1);

  state_t      state, state_nxt;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [1:0]  off;
  logic        size_ok;
  logic        misalign;
  logic        access;
  logic        fast_store;

  function automatic logic [3:0] be_map(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   be_map = 4'b0001 << o;
      2'b01:   be_map = 4'b0011 << {o[1], 1'b0};
      default: be_map = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] sz,
                                          input logic [1:0] o);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {o, 3'b000};
    b       = shifted[7:0];
    h       = o[1] ? w[31:16] : w[15:0];
    case (sz)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd2:    extract = w;
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = 32'd0;
    endcase
  endfunction

  assign off = lsu_addr_i[1:0];

  always_comb begin
    case (lsu_size_i)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: size_ok = 1'b1;
      default:                      size_ok = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = ((lsu_size_i[1:0] == 2'b01) && off[0]) ||
                    ((lsu_size_i[1:0] == 2'b10) && (off != 2'b00));
  assign lsu_misaligned_o = reset && (state == IDLE) && lsu_req_i && size_ok && misalign;
`else
  assign misalign = 1'b0;
`endif

  // Only IDLE may launch an access, so a request held through DONE is not re-issued.
  assign access     = reset && (state == IDLE) && lsu_req_i && size_ok && !misalign;
  assign fast_store = lsu_we_i && !STALL_ON_STORE;

  always_comb begin
    state_nxt              = state;
    data_require_o         = 1'b0;
    data_write_enable_o    = 1'b0;
    data_byte_enable_map_o = 4'b0000;
    data_address_o         = 32'd0;
    data_write_o           = 32'd0;
    lsu_stall_req_o        = 1'b0;
    lsu_data_o             = 32'd0;
    case (state)
      IDLE: begin
        if (access) begin
          data_require_o      = 1'b1;
          data_write_enable_o = lsu_we_i;
          data_address_o      = lsu_addr_i & ADDR_MASK;
          if (lsu_we_i) begin
            data_byte_enable_map_o = be_map(lsu_size_i[1:0], off);
            data_write_o           = lane_data(lsu_size_i[1:0], lsu_data_i);
          end else begin
            data_byte_enable_map_o = 4'b1111;
          end
          if (!fast_store) begin
            lsu_stall_req_o = 1'b1;
            state_nxt       = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (reset) lsu_data_o = extract(data_read_i, size_q, off_q);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request/response boundary: offset and size captured for the DONE-cycle extraction
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      off_q  <= 2'b00;
      size_q <= 3'd0;
    end else begin
      state <= state_nxt;
      if (access) begin
        off_q  <= off;
        size_q <= lsu_size_i;
      end
    end
  end

endmodule
